// File: rtl/phys_reg_free_list_pkg.sv
// rtl/phys_reg_free_list_pkg.sv - shared constants and types for the physical register free list
//
// Purpose: constants and types shared by the free list, the rename stage and the register file.
//   ALLOC_WIDTH : number of tag slots offered per cycle (width of the Free_regs bus in slots).
//   log_phys()  : tag width for a given physical register count.
//   phys_tag_t  : physical register tag for the default register-file size.
package phys_reg_free_list_pkg;

    localparam int ALLOC_WIDTH       = 3;
    localparam int DEFAULT_PHYS_REGS = 64;

    function automatic int log_phys(input int num_regs);
        return $clog2(num_regs);
    endfunction

    localparam int LOG_PHYS = log_phys(DEFAULT_PHYS_REGS);

    typedef logic [LOG_PHYS-1:0] phys_tag_t;

endpackage

// File: rtl/phys_tag_ring.sv
// rtl/phys_tag_ring.sv - circular tag storage, one write port, three consecutive read ports
//
// Purpose: holds the free-list entries. The reset image lists the initially unmapped
// tags ARCH..DEPTH-1 at entries 0..DEPTH-ARCH-1; the remaining entries reset to 0.
// Ports:
//   CLK, RESET      clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data   write port (registered)
//   rd_addr         base read index; rd_data slot k = entry[rd_addr + k] (combinational)
module phys_tag_ring
    import phys_reg_free_list_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int ARCH  = 32,
    parameter int L     = log_phys(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     wr_en,
    input  logic [L-1:0]             wr_addr,
    input  logic [L-1:0]             wr_data,
    input  logic [L-1:0]             rd_addr,
    output logic [ALLOC_WIDTH*L-1:0] rd_data
);

    logic [L-1:0] mem [DEPTH];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i < DEPTH - ARCH) ? L'(ARCH + i) : '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Index arithmetic is L bits wide, so reads past the last entry wrap to the start.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            rd_data[k*L +: L] = mem[rd_addr + L'(k)];
        end
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - physical register free list with commit reclaim and flush rollback
//
// Purpose: offers up to three free tags per cycle to rename, takes tags back at commit,
// and rewinds speculative allocations on a flush.
// Ports:
//   CLK, RESET           clock, asynchronous active-low reset
//   Alloc_IN             prefix mask of slots consumed this cycle
//   Free_regs_OUT        three candidate tags (slot k at [k*L +: L])
//   Free_regs_sel_OUT    slot k valid when count > k
//   FreeReg_IN/SetFree_IN tag returned at commit and its push strobe
//   Retire_IN            allocations that became non-speculative this cycle
//   Recover_IN           flush: head rewinds to the retire pointer
//   Count_OUT            free entries (tail - head)
//   Error_OUT            sticky protocol-error flag
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
#(
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_ARCH_REGS = 32,
    localparam int L = log_phys(NUM_PHYS_REGS)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [ALLOC_WIDTH-1:0]   Alloc_IN,
    output logic [ALLOC_WIDTH*L-1:0] Free_regs_OUT,
    output logic [ALLOC_WIDTH-1:0]   Free_regs_sel_OUT,
    input  logic [L-1:0]             FreeReg_IN,
    input  logic                     SetFree_IN,
    input  logic [1:0]               Retire_IN,
    input  logic                     Recover_IN,
    output logic [L:0]               Count_OUT,
    output logic                     Error_OUT
);

    // Pointers carry a wrap bit above the index so full and empty differ.
    typedef logic [L:0] ptr_t;

    ptr_t head;
    ptr_t retire_head;
    ptr_t tail;
    logic error_flag;

    ptr_t count;
    ptr_t n_alloc;
    ptr_t spec_cnt;
    ptr_t retire_amt;
    ptr_t retire_next;
    ptr_t head_next;
    logic prefix_ok;
    logic do_alloc;
    logic alloc_err;
    logic full;
    logic free_err;
    logic retire_err;

    always_comb begin
        count = tail - head;

        prefix_ok = 1'b0;
        case (Alloc_IN)
            3'b000, 3'b001, 3'b011, 3'b111: prefix_ok = 1'b1;
            default:                        prefix_ok = 1'b0;
        endcase

        n_alloc = ptr_t'(Alloc_IN[0]) + ptr_t'(Alloc_IN[1]) + ptr_t'(Alloc_IN[2]);

        // A flush swallows the same-cycle allocation without flagging it.
        do_alloc  = !Recover_IN && prefix_ok && (n_alloc <= count);
        alloc_err = !Recover_IN && (!prefix_ok || (n_alloc > count));

        full     = (count == ptr_t'(NUM_PHYS_REGS));
        free_err = SetFree_IN && full;

        // Retiring more than is outstanding clamps the retire pointer to head.
        spec_cnt    = head - retire_head;
        retire_amt  = ptr_t'(Retire_IN);
        retire_err  = (retire_amt > spec_cnt);
        retire_next = retire_err ? head : (retire_head + retire_amt);

        head_next = head;
        if (Recover_IN) begin
            head_next = retire_next;
        end else if (do_alloc) begin
            head_next = head + n_alloc;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head        <= '0;
            retire_head <= '0;
            tail        <= ptr_t'(NUM_PHYS_REGS - NUM_ARCH_REGS);
            error_flag  <= 1'b0;
        end else begin
            head        <= head_next;
            retire_head <= retire_next;
            if (SetFree_IN && !full) begin
                tail <= tail + ptr_t'(1);
            end
            if (alloc_err || free_err || retire_err) begin
                error_flag <= 1'b1;
            end
        end
    end

    phys_tag_ring #(
        .DEPTH (NUM_PHYS_REGS),
        .ARCH  (NUM_ARCH_REGS),
        .L     (L)
    ) u_ring (
        .CLK     (CLK),
        .RESET   (RESET),
        .wr_en   (SetFree_IN && !full),
        .wr_addr (tail[L-1:0]),
        .wr_data (FreeReg_IN),
        .rd_addr (head[L-1:0]),
        .rd_data (Free_regs_OUT)
    );

    always_comb begin
        Free_regs_sel_OUT = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            Free_regs_sel_OUT[k] = (count > ptr_t'(k));
        end
    end

    assign Count_OUT = count;
    assign Error_OUT = error_flag;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb/tb_phys_reg_free_list.sv - directed self-checking bench for phys_reg_free_list
module tb_phys_reg_free_list;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [2:0]  Alloc_IN;
    logic [17:0] Free_regs_OUT;
    logic [2:0]  Free_regs_sel_OUT;
    logic [5:0]  FreeReg_IN;
    logic        SetFree_IN;
    logic [1:0]  Retire_IN;
    logic        Recover_IN;
    logic [6:0]  Count_OUT;
    logic        Error_OUT;

    int n_cmp = 0;
    int n_bad = 0;

    phys_reg_free_list #(
        .NUM_PHYS_REGS (64),
        .NUM_ARCH_REGS (32)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .Alloc_IN          (Alloc_IN),
        .Free_regs_OUT     (Free_regs_OUT),
        .Free_regs_sel_OUT (Free_regs_sel_OUT),
        .FreeReg_IN        (FreeReg_IN),
        .SetFree_IN        (SetFree_IN),
        .Retire_IN         (Retire_IN),
        .Recover_IN        (Recover_IN),
        .Count_OUT         (Count_OUT),
        .Error_OUT         (Error_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        Alloc_IN   = 3'b000;
        SetFree_IN = 1'b0;
        FreeReg_IN = 6'd0;
        Retire_IN  = 2'd0;
        Recover_IN = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (Free_regs_OUT[k*6 +: 6] !== 6'(32 + k)) begin
                $display("FAIL reset_slot%0d got %0d want %0d", k, Free_regs_OUT[k*6 +: 6], 32 + k);
                n_bad++;
            end
        end
        n_cmp++;
        if (Free_regs_sel_OUT !== 3'b111) begin
            $display("FAIL reset_sel got %b want 111", Free_regs_sel_OUT); n_bad++;
        end
        n_cmp++;
        if (Count_OUT !== 7'd32) begin
            $display("FAIL reset_count got %0d want 32", Count_OUT); n_bad++;
        end
        n_cmp++;
        if (Error_OUT !== 1'b0) begin
            $display("FAIL reset_error got %b want 0", Error_OUT); n_bad++;
        end
    endtask

    task automatic test_drain();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            Alloc_IN = 3'b111;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (Free_regs_OUT[k*6 +: 6] !== 6'(32 + 3*c + k)) begin
                    $display("FAIL drain_c%0d_slot%0d got %0d want %0d", c, k,
                             Free_regs_OUT[k*6 +: 6], 32 + 3*c + k);
                    n_bad++;
                end
            end
            tick();
        end
        Alloc_IN = 3'b011;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (Free_regs_OUT[k*6 +: 6] !== 6'(62 + k)) begin
                $display("FAIL drain_last_slot%0d got %0d want %0d", k, Free_regs_OUT[k*6 +: 6], 62 + k);
                n_bad++;
            end
        end
        tick();
        idle_inputs();
        n_cmp++;
        if (Count_OUT !== 7'd0) begin
            $display("FAIL drain_count got %0d want 0", Count_OUT); n_bad++;
        end
        n_cmp++;
        if (Free_regs_sel_OUT !== 3'b000) begin
            $display("FAIL drain_sel got %b want 000", Free_regs_sel_OUT); n_bad++;
        end
        n_cmp++;
        if (Error_OUT !== 1'b0) begin
            $display("FAIL drain_error_early got %b want 0", Error_OUT); n_bad++;
        end
        Alloc_IN = 3'b001;
        tick();
        idle_inputs();
        n_cmp++;
        if (Error_OUT !== 1'b1) begin
            $display("FAIL underflow_error got %b want 1", Error_OUT); n_bad++;
        end
        n_cmp++;
        if (Count_OUT !== 7'd0) begin
            $display("FAIL underflow_count got %0d want 0", Count_OUT); n_bad++;
        end
    endtask

    task automatic test_recover();
        do_reset();
        Alloc_IN = 3'b111;
        tick();
        Alloc_IN = 3'b011;
        tick();
        idle_inputs();
        n_cmp++;
        if (Count_OUT !== 7'd27) begin
            $display("FAIL recover_pre_count got %0d want 27", Count_OUT); n_bad++;
        end
        Retire_IN = 2'd2;
        tick();
        idle_inputs();
        Recover_IN = 1'b1;
        Alloc_IN   = 3'b111;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (Free_regs_OUT[k*6 +: 6] !== 6'(34 + k)) begin
                $display("FAIL recover_slot%0d got %0d want %0d", k, Free_regs_OUT[k*6 +: 6], 34 + k);
                n_bad++;
            end
        end
        n_cmp++;
        if (Count_OUT !== 7'd30) begin
            $display("FAIL recover_count got %0d want 30", Count_OUT); n_bad++;
        end
        n_cmp++;
        if (Error_OUT !== 1'b0) begin
            $display("FAIL recover_error got %b want 0", Error_OUT); n_bad++;
        end
    endtask

    task automatic test_free_empty();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            Alloc_IN = 3'b111;
            tick();
        end
        Alloc_IN = 3'b011;
        tick();
        idle_inputs();
        SetFree_IN = 1'b1;
        FreeReg_IN = 6'd7;
        n_cmp++;
        if (Free_regs_sel_OUT !== 3'b000) begin
            $display("FAIL nobypass_sel got %b want 000", Free_regs_sel_OUT); n_bad++;
        end
        tick();
        idle_inputs();
        n_cmp++;
        if (Free_regs_OUT[5:0] !== 6'd7) begin
            $display("FAIL freed_slot0 got %0d want 7", Free_regs_OUT[5:0]); n_bad++;
        end
        n_cmp++;
        if (Free_regs_sel_OUT !== 3'b001) begin
            $display("FAIL freed_sel got %b want 001", Free_regs_sel_OUT); n_bad++;
        end
        n_cmp++;
        if (Count_OUT !== 7'd1) begin
            $display("FAIL freed_count got %0d want 1", Count_OUT); n_bad++;
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            SetFree_IN = 1'b1;
            FreeReg_IN = 6'(i);
            tick();
        end
        idle_inputs();
        n_cmp++;
        if (Count_OUT !== 7'd64) begin
            $display("FAIL fill_count got %0d want 64", Count_OUT); n_bad++;
        end
        n_cmp++;
        if (Error_OUT !== 1'b0) begin
            $display("FAIL fill_error got %b want 0", Error_OUT); n_bad++;
        end
        SetFree_IN = 1'b1;
        FreeReg_IN = 6'd9;
        tick();
        idle_inputs();
        n_cmp++;
        if (Error_OUT !== 1'b1) begin
            $display("FAIL overflow_error got %b want 1", Error_OUT); n_bad++;
        end
        n_cmp++;
        if (Count_OUT !== 7'd64) begin
            $display("FAIL overflow_count got %0d want 64", Count_OUT); n_bad++;
        end
        n_cmp++;
        if (Free_regs_OUT[5:0] !== 6'd32) begin
            $display("FAIL overflow_slot0 got %0d want 32", Free_regs_OUT[5:0]); n_bad++;
        end
        for (int c = 0; c < 10; c++) begin
            Alloc_IN = 3'b111;
            tick();
        end
        Alloc_IN = 3'b011;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (Free_regs_OUT[k*6 +: 6] !== 6'(k)) begin
                $display("FAIL wrap_slot%0d got %0d want %0d", k, Free_regs_OUT[k*6 +: 6], k);
                n_bad++;
            end
        end
        n_cmp++;
        if (Count_OUT !== 7'd32) begin
            $display("FAIL wrap_count got %0d want 32", Count_OUT); n_bad++;
        end
    endtask

    task automatic test_illegal_and_async_reset();
        do_reset();
        Alloc_IN = 3'b101;
        tick();
        idle_inputs();
        n_cmp++;
        if (Error_OUT !== 1'b1) begin
            $display("FAIL nonprefix_error got %b want 1", Error_OUT); n_bad++;
        end
        n_cmp++;
        if (Count_OUT !== 7'd32) begin
            $display("FAIL nonprefix_count got %0d want 32", Count_OUT); n_bad++;
        end
        n_cmp++;
        if (Free_regs_OUT[5:0] !== 6'd32) begin
            $display("FAIL nonprefix_slot0 got %0d want 32", Free_regs_OUT[5:0]); n_bad++;
        end
        Alloc_IN = 3'b111;
        tick();
        idle_inputs();
        n_cmp++;
        if (Free_regs_OUT[5:0] !== 6'd35) begin
            $display("FAIL post_alloc_slot0 got %0d want 35", Free_regs_OUT[5:0]); n_bad++;
        end
        #2;
        RESET = 1'b0;
        #1;
        n_cmp++;
        if (Error_OUT !== 1'b0) begin
            $display("FAIL async_reset_error got %b want 0", Error_OUT); n_bad++;
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (Free_regs_OUT[k*6 +: 6] !== 6'(32 + k)) begin
                $display("FAIL async_reset_slot%0d got %0d want %0d", k, Free_regs_OUT[k*6 +: 6], 32 + k);
                n_bad++;
            end
        end
        tick();
        RESET = 1'b1;
    endtask

    task automatic test_retire_overflow();
        do_reset();
        Alloc_IN = 3'b001;
        tick();
        idle_inputs();
        Retire_IN = 2'd3;
        tick();
        idle_inputs();
        n_cmp++;
        if (Error_OUT !== 1'b1) begin
            $display("FAIL retire_over_error got %b want 1", Error_OUT); n_bad++;
        end
        Recover_IN = 1'b1;
        tick();
        idle_inputs();
        n_cmp++;
        if (Count_OUT !== 7'd31) begin
            $display("FAIL retire_clamp_count got %0d want 31", Count_OUT); n_bad++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        Alloc_IN   = 3'b111;
        SetFree_IN = 1'b1;
        FreeReg_IN = 6'd5;
        tick();
        idle_inputs();
        n_cmp++;
        if (Count_OUT !== 7'd30) begin
            $display("FAIL alloc_free_count got %0d want 30", Count_OUT); n_bad++;
        end
        n_cmp++;
        if (Free_regs_OUT[5:0] !== 6'd35) begin
            $display("FAIL alloc_free_slot0 got %0d want 35", Free_regs_OUT[5:0]); n_bad++;
        end
        n_cmp++;
        if (Error_OUT !== 1'b0) begin
            $display("FAIL alloc_free_error got %b want 0", Error_OUT); n_bad++;
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_drain();
        test_recover();
        test_free_empty();
        test_fill();
        test_illegal_and_async_reset();
        test_retire_overflow();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Free-list allocator for the physical register file. It hands up to three free physical register tags per cycle to the rename stage, reclaims tags released at commit, and rolls speculative allocations back on a pipeline flush. The block sits between rename/commit and the physical register file, and owns which physical registers are unmapped.

## Interface
- NUM_PHYS_REGS, 64, physical register count; must be a power of two and at least 4.
- NUM_ARCH_REGS, 32, registers mapped at reset (tags 0..NUM_ARCH_REGS-1); must be less than NUM_PHYS_REGS.
- L = $clog2(NUM_PHYS_REGS), used in the widths below.
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  reset; one clock, asynchronous and active-low (0 = reset).
- Alloc_IN  in  3  consume mask; legal values 000/001/011/111 (prefix of slots 0..2).
- Free_regs_OUT  out  3*L  candidate tags; slot k is bits [k*L +: L].
- Free_regs_sel_OUT  out  3  slot-valid mask: bit k = (count > k).
- FreeReg_IN  in  L  tag returned at commit.
- SetFree_IN  in  1  push FreeReg_IN onto the list.
- Retire_IN  in  2  number (0..3) of allocations that became non-speculative this cycle.
- Recover_IN  in  1  flush: discard all unretired allocations.
- Count_OUT  out  L+1  free entries (tail - head).
- Error_OUT  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- Storage: circular array of NUM_PHYS_REGS entries × L bits. Pointers head, retire_head and tail are L+1 bits (wrap bit + index); index = pointer modulo NUM_PHYS_REGS.
- Reset values:
  - entry[i] = NUM_ARCH_REGS + i for i < NUM_PHYS_REGS - NUM_ARCH_REGS; other entries are 0.
  - head = retire_head = 0; tail = NUM_PHYS_REGS - NUM_ARCH_REGS.
  - Error_OUT = 0; Count_OUT = NUM_PHYS_REGS - NUM_ARCH_REGS; Free_regs_sel_OUT = 111.
- Outputs:
  - Slot k shows entry[head+k] and is combinational from registered state.
  - Slots beyond count are don't-care and are not qualified by sel.
- Allocation:
  - n = popcount(Alloc_IN); head += n.
  - Illegal cases are ignored (head unchanged) and set Error_OUT: n > count, or a non-prefix mask.
- Free:
  - SetFree_IN writes entry[tail] = FreeReg_IN, then tail += 1.
  - If count == NUM_PHYS_REGS the push is dropped and Error_OUT is set.
- Retire:
  - retire_head += Retire_IN.
  - If Retire_IN > head - retire_head, retire_head is clamped to head and Error_OUT is set.
- Recover: head <= retire_head (the value after this cycle's retire), restoring every speculatively allocated tag to the list.
- Same-cycle priority:
  - Recover_IN overrides Alloc_IN: the allocation is ignored and no error is raised.
  - Retire and free are always applied, including with recover.
  - Alloc and free in the same cycle are both applied.
- No bypass: a tag freed in cycle t is not visible in the slots before cycle t+1, even when count == 0.
- Arithmetic:
  - All pointer sums are L+1 bits and wrap naturally.
  - count = tail - head (L+1 bits), so full (NUM_PHYS_REGS) and empty (0) are distinguishable.

## Timing
- Allocation latency: tags consumed at edge t. The next three tags appear in the slots after edge t; no bubble.
- Free latency: 1 cycle from SetFree_IN to the tag appearing at the tail.
- Recovery latency: 1 cycle; restored tags are visible in the slots the cycle after Recover_IN.
- RESET low mid-operation immediately forces all reset values, asynchronously. In-flight requests in that cycle are lost.
- No handshake stalls. Rename must consume only slots whose sel bit is set.

## Structure
- Shared package holds:
  - the LOG_PHYS macro/function;
  - phys_tag_t (L bits);
  - the ALLOC_WIDTH = 3 constant, also used by the rename stage and the register file's Free_regs bus.
- One sub-module is natural: phys_tag_ring. It holds the circular storage with one write port and three read ports at consecutive addresses. The free-list controller (pointers, checks, recovery) stays in the top module.

## Test plan
- Reset, no activity: slots = 32, 33, 34; sel = 111; Count_OUT = 32; Error_OUT = 0.
- Alloc_IN = 111 for 10 cycles, then 011: the 32 tags come out in order 32..63. Count_OUT reaches 0 and sel = 000. A further Alloc_IN = 001 sets Error_OUT and head does not move.
- Allocate 5 tags (32..36) and retire 2, then assert Recover_IN together with Alloc_IN = 111. Next cycle: slots = 34, 35, 36 and Count_OUT = 30; Error_OUT stays 0.
- Empty list, then SetFree_IN with tag 7: sel = 000 in the same cycle. Next cycle: slot0 = 7 and sel = 001.
- Fill the list to NUM_PHYS_REGS by freeing 32 tags after reset: Count_OUT = 64. One more SetFree_IN is dropped and sets Error_OUT.
- Alloc_IN = 101 → Error_OUT = 1 and head unchanged. RESET low mid-stream → Error_OUT = 0 and slots = 32, 33, 34.
